// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the memory_controller data port
// Define MEM_ARB_STARVE_EN to add the port 1 anti-starvation counter (wait_cnt / MAX_WAIT).
module mem_port_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_is_store,
  input  logic        m0_is_load,
  input  logic [2:0]  m0_wren,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_is_store,
  input  logic        m1_is_load,
  input  logic [2:0]  m1_wren,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic        mc_is_store,
  output logic        mc_is_load,
  output logic [2:0]  mc_wren,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  input  logic [31:0] mc_r_data
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must be >= 1");
  end

  logic m0_eff;
  logic m1_eff;
  logic force_m1;
  logic load_gnt;
  logic rd_pend;
  logic rd_owner;

  // A request counts only with exactly one of is_store / is_load set.
  assign m0_eff = m0_req && (m0_is_store ^ m0_is_load);
  assign m1_eff = m1_req && (m1_is_store ^ m1_is_load);

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;

  assign force_m1 = m1_eff && (wait_cnt == CNT_MAX);

  always_comb begin
    wait_cnt_next = wait_cnt;
    if (!m1_eff || m1_gnt) begin
      wait_cnt_next = '0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_cnt_next = wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end
`else
  assign force_m1 = 1'b0;
`endif

  assign m1_gnt = m1_eff && (!m0_eff || force_m1);
  assign m0_gnt = m0_eff && !force_m1;

  always_comb begin
    mc_is_store = 1'b0;
    mc_is_load  = 1'b0;
    mc_wren     = 3'b111;
    mc_addr     = '0;
    mc_wdata    = '0;
    if (m1_gnt) begin
      mc_is_store = m1_is_store;
      mc_is_load  = m1_is_load;
      mc_wren     = m1_wren;
      mc_addr     = m1_addr;
      mc_wdata    = m1_wdata;
    end else if (m0_gnt) begin
      mc_is_store = m0_is_store;
      mc_is_load  = m0_is_load;
      mc_wren     = m0_wren;
      mc_addr     = m0_addr;
      mc_wdata    = m0_wdata;
    end
  end

  assign load_gnt = (m0_gnt && m0_is_load) || (m1_gnt && m1_is_load);

  // The RAM answers one cycle later, so remember who asked; rewritten every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= load_gnt;
      if (load_gnt) begin
        rd_owner <= m1_gnt;
      end
    end
  end

  assign m0_rvalid = rd_pend && !rd_owner;
  assign m1_rvalid = rd_pend && rd_owner;
  assign m0_rdata  = m0_rvalid ? mc_r_data : '0;
  assign m1_rdata  = m1_rvalid ? mc_r_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Honours MEM_ARB_STARVE_EN the same way as the design.
module tb_mem_port_arbiter;
  localparam int MAX_WAIT = 3;
  localparam logic [31:0] UART_ADDR = 32'h0000_03F0;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 0, m0_is_store = 0, m0_is_load = 0;
  logic [2:0]  m0_wren = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic        m1_req = 0, m1_is_store = 0, m1_is_load = 0;
  logic [2:0]  m1_wren = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mc_is_store, mc_is_load;
  logic [2:0]  mc_wren;
  logic [31:0] mc_addr, mc_wdata;
  logic [31:0] mc_r_data = 0;

  int errors = 0;
  int checks = 0;
  logic [31:0] ram [0:255];

  mem_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_is_store(m0_is_store), .m0_is_load(m0_is_load),
    .m0_wren(m0_wren), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_is_store(m1_is_store), .m1_is_load(m1_is_load),
    .m1_wren(m1_wren), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mc_is_store(mc_is_store), .mc_is_load(mc_is_load), .mc_wren(mc_wren),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_r_data(mc_r_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0103;
  endfunction

  // Stand-in for memory_controller: synchronous read, byte/half/word writes.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(i);
    end else if (mc_is_store) begin
      case (mc_wren)
        3'b000: ram[mc_addr[9:2]][{mc_addr[1:0], 3'b000} +: 8] <= mc_wdata[7:0];
        3'b001: ram[mc_addr[9:2]][{mc_addr[1], 4'b0000} +: 16] <= mc_wdata[15:0];
        3'b010: ram[mc_addr[9:2]] <= mc_wdata;
        default: ;
      endcase
    end
    if (mc_is_load) mc_r_data <= ram[mc_addr[9:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic rq, st, ld, input logic [2:0] wr, input logic [31:0] a, d);
    m0_req = rq; m0_is_store = st; m0_is_load = ld; m0_wren = wr; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drive1(input logic rq, st, ld, input logic [2:0] wr, input logic [31:0] a, d);
    m1_req = rq; m1_is_store = st; m1_is_load = ld; m1_wren = wr; m1_addr = a; m1_wdata = d;
  endtask

  task automatic idle();
    drive0(0, 0, 0, 3'b000, 0, 0);
    drive1(0, 0, 0, 3'b000, 0, 0);
  endtask

  task automatic test_reset();
    idle();
    #2;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid}); end
    checks++; if (mc_wren !== 3'b111) begin errors++; $display("FAIL reset_idle_wren: got %b expected 111", mc_wren); end
    checks++; if ({m0_gnt, m1_gnt, mc_is_store, mc_is_load} !== 4'b0000) begin errors++; $display("FAIL reset_idle_gnt: got %b expected 0000", {m0_gnt, m1_gnt, mc_is_store, mc_is_load}); end
    drive0(1, 0, 1, 3'b010, 32'h40, 0);
    #1;
    checks++; if ({m0_gnt, mc_is_load} !== 2'b11) begin errors++; $display("FAIL reset_comb_grant: got %b expected 11", {m0_gnt, mc_is_load}); end
    tick();
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL reset_no_rvalid: got %b expected 0", m0_rvalid); end
    idle();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_load();
    drive0(1, 1, 0, 3'b010, 32'h6100, 32'hDEAD_BEEF);
    #1;
    checks++; if ({m0_gnt, mc_is_store, mc_addr} !== {2'b11, 32'h6100}) begin errors++; $display("FAIL store_grant: got %b %b %h expected 1 1 00006100", m0_gnt, mc_is_store, mc_addr); end
    tick();
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL store_no_resp: got %b expected 0", m0_rvalid); end
    drive0(1, 0, 1, 3'b010, 32'h6100, 0);
    #1;
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL load_grant: got %b expected 1", m0_gnt); end
    tick();
    idle();
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL load_rvalid: got %b expected 1", m0_rvalid); end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata: got %h expected deadbeef", m0_rdata); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL load_other_rvalid: got %b expected 0", m1_rvalid); end
    tick();
  endtask

  task automatic test_contention();
    logic exp1;
    drive0(1, 0, 1, 3'b010, 32'h28, 0);
    drive1(1, 0, 1, 3'b010, 32'h50, 0);
    for (int c = 1; c <= 12; c++) begin
      #1;
      exp1 = STARVE && (c % (MAX_WAIT + 1) == 0);
      checks++; if ({m0_gnt, m1_gnt} !== {~exp1, exp1}) begin errors++; $display("FAIL contention_gnt c=%0d: got %b%b expected %b%b", c, m0_gnt, m1_gnt, ~exp1, exp1); end
      tick();
      checks++; if ({m0_rvalid, m1_rvalid} !== {~exp1, exp1}) begin errors++; $display("FAIL contention_rvalid c=%0d: got %b%b expected %b%b", c, m0_rvalid, m1_rvalid, ~exp1, exp1); end
      checks++; if ((exp1 ? m1_rdata : m0_rdata) !== (exp1 ? pat(20) : pat(10))) begin errors++; $display("FAIL contention_rdata c=%0d: got %h expected %h", c, exp1 ? m1_rdata : m0_rdata, exp1 ? pat(20) : pat(10)); end
    end
    idle();
    tick();
  endtask

  task automatic test_interleaved();
    int idx;
    logic p;
    for (int k = 0; k < 8; k++) begin
      idx = $urandom_range(0, 63);
      p = k[0];
      idle();
      if (p) drive1(1, 0, 1, 3'b010, 32'(idx) << 2, 0);
      else   drive0(1, 0, 1, 3'b010, 32'(idx) << 2, 0);
      #1;
      checks++; if ({m0_gnt, m1_gnt} !== {~p, p}) begin errors++; $display("FAIL inter_gnt k=%0d: got %b%b expected %b%b", k, m0_gnt, m1_gnt, ~p, p); end
      tick();
      checks++; if ({m0_rvalid, m1_rvalid} !== {~p, p}) begin errors++; $display("FAIL inter_rvalid k=%0d: got %b%b expected %b%b", k, m0_rvalid, m1_rvalid, ~p, p); end
      checks++; if ((p ? m1_rdata : m0_rdata) !== pat(idx) || (p ? m0_rdata : m1_rdata) !== 32'h0) begin errors++; $display("FAIL inter_rdata k=%0d: got %h/%h expected %h/0", k, p ? m1_rdata : m0_rdata, p ? m0_rdata : m1_rdata, pat(idx)); end
    end
    idle();
    tick();
  endtask

  task automatic test_uart();
    int stores = 0;
    drive1(1, 1, 0, 3'b000, UART_ADDR, 32'h1234_5641);
    #1;
    checks++; if ({m1_gnt, mc_wren, mc_wdata[7:0]} !== {1'b1, 3'b000, 8'h41}) begin errors++; $display("FAIL uart_access: got %b %b %h expected 1 000 41", m1_gnt, mc_wren, mc_wdata[7:0]); end
    if (mc_is_store) stores++;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      if (mc_is_store) stores++;
      tick();
    end
    checks++; if (stores !== 1) begin errors++; $display("FAIL uart_single_store: got %0d expected 1", stores); end
  endtask

  task automatic test_idle_malformed();
    idle();
    #1;
    checks++; if ({mc_wren, mc_is_store, mc_is_load} !== 5'b11100) begin errors++; $display("FAIL idle_mc: got %b expected 11100", {mc_wren, mc_is_store, mc_is_load}); end
    drive0(1, 1, 1, 3'b010, 32'h10, 32'h55);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({m0_gnt, mc_is_store, mc_is_load} !== 3'b000) begin errors++; $display("FAIL malformed_gnt k=%0d: got %b expected 000", k, {m0_gnt, mc_is_store, mc_is_load}); end
      tick();
    end
    drive1(1, 0, 1, 3'b010, 32'h14, 0);
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL malformed_vs_m1: got %b expected 01", {m0_gnt, m1_gnt}); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid_load();
    logic exp1;
    drive0(1, 0, 1, 3'b010, 32'h14, 0);
    drive1(1, 0, 1, 3'b010, 32'h18, 0);
    tick();
    tick();
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_rvalid: got %b expected 1", m0_rvalid); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL async_reset_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid}); end
    tick();
    reset = 1'b1;
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid: got %b expected 0", m0_rvalid); end
    for (int c = 1; c <= 8; c++) begin
      #1;
      exp1 = STARVE && (c % (MAX_WAIT + 1) == 0);
      checks++; if ({m0_gnt, m1_gnt} !== {~exp1, exp1}) begin errors++; $display("FAIL post_reset_gnt c=%0d: got %b%b expected %b%b", c, m0_gnt, m1_gnt, ~exp1, exp1); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    logic        rq [2], st [2], ld [2], held [2], eff [2], g [2];
    logic [2:0]  wr [2];
    logic [31:0] ad [2], wd [2];
    int          kind, idx, waited, ld_owner, ld_idx;
    logic        ld_pend, exp_st, exp_ld;
    logic [31:0] exp_addr;
    waited = 0;
    ld_pend = 0; ld_owner = 0; ld_idx = 0;
    for (int p = 0; p < 2; p++) held[p] = 0;
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!held[p]) begin
          kind = $urandom_range(0, 5);
          rq[p] = (kind != 0);
          st[p] = (kind == 2) || (kind == 4);
          ld[p] = (kind == 1) || (kind == 3) || (kind == 4);
          if (kind == 2) begin
            idx = $urandom_range(128, 255);
            wr[p] = 3'($urandom_range(0, 2));
          end else begin
            idx = $urandom_range(0, 127);
            wr[p] = 3'b010;
          end
          ad[p] = (32'(idx) << 2) | ((kind == 2) ? 32'($urandom_range(0, 3)) & 32'h2 : 32'h0);
          wd[p] = $urandom;
        end
        eff[p] = rq[p] && (st[p] != ld[p]);
      end
      drive0(rq[0], st[0], ld[0], wr[0], ad[0], wd[0]);
      drive1(rq[1], st[1], ld[1], wr[1], ad[1], wd[1]);
      g[1] = eff[1] && (!eff[0] || (STARVE && waited == MAX_WAIT));
      g[0] = eff[0] && !(STARVE && eff[1] && waited == MAX_WAIT);
      exp_st = g[1] ? st[1] : (g[0] ? st[0] : 1'b0);
      exp_ld = g[1] ? ld[1] : (g[0] ? ld[0] : 1'b0);
      exp_addr = g[1] ? ad[1] : (g[0] ? ad[0] : 32'h0);
      #1;
      checks++; if ({m0_gnt, m1_gnt} !== {g[0], g[1]}) begin errors++; $display("FAIL rand_gnt n=%0d: got %b%b expected %b%b", n, m0_gnt, m1_gnt, g[0], g[1]); end
      checks++; if ({mc_is_store, mc_is_load, mc_addr} !== {exp_st, exp_ld, exp_addr}) begin errors++; $display("FAIL rand_mc n=%0d: got %b%b %h expected %b%b %h", n, mc_is_store, mc_is_load, mc_addr, exp_st, exp_ld, exp_addr); end
      ld_pend = exp_ld;
      ld_owner = g[1] ? 1 : 0;
      ld_idx = exp_addr[9:2];
      waited = (!eff[1] || g[1]) ? 0 : ((waited < MAX_WAIT) ? waited + 1 : MAX_WAIT);
      for (int p = 0; p < 2; p++) held[p] = eff[p] && !g[p];
      tick();
      checks++; if ({m0_rvalid, m1_rvalid} !== {ld_pend && ld_owner == 0, ld_pend && ld_owner == 1}) begin errors++; $display("FAIL rand_rvalid n=%0d: got %b%b expected %b%b", n, m0_rvalid, m1_rvalid, ld_pend && ld_owner == 0, ld_pend && ld_owner == 1); end
      if (ld_pend) begin
        checks++; if ((ld_owner == 1 ? m1_rdata : m0_rdata) !== pat(ld_idx)) begin errors++; $display("FAIL rand_rdata n=%0d: got %h expected %h", n, ld_owner == 1 ? m1_rdata : m0_rdata, pat(ld_idx)); end
      end
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_interleaved();
    test_uart();
    test_idle_malformed();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
